rf_port_arb: RTL and testbench

//  Arbitrates one single-port register-file RAM between NUM_REQ requesters:
//  the move engine, the compute operand fetch and the DMA fill path.
//  - Round-robin grant, decided in the same cycle as the request.
//  - Requesters may lock the port for back-to-back accesses, e.g. the

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_rr_pick.sv | 35 +++
 rtl/rf_port_arb.sv | 135 +++++++++++++
 tb/tb_rf_port_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file defaults and types for the RF port arbiter.
// Used by rf_port_arb and rf_rr_pick.
package rf_pkg;

  localparam int RF_WIDTH  = 1408;
  localparam int RF_ADDR_W = 9;

  typedef enum logic {
    ARB,
    OWN
  } rf_arb_state_t;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_rr_pick.sv
// Combinational round-robin one-hot picker.
// The search starts at ptr+1 and wraps modulo N.
module rf_rr_pick
  import rf_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int          j;
  logic [IW-1:0] jj;

  // Walk the farthest slot first so the nearest requester wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    jj  = '0;
    for (int k = N; k >= 1; k--) begin
      j  = (int'(ptr) + k) % N;
      jj = IW'(j);
      if (req[jj]) begin
        gnt     = '0;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/rf_port_arb.sv
// Single-port RF RAM arbiter: round-robin grant with lock/ownership.
// Define RF_ARB_PRIO0_EN to give requester 0 absolute priority in ARB.
module rf_port_arb
  import rf_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int WIDTH    = RF_WIDTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int MAX_HOLD = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                lock,
  input  logic [NUM_REQ-1:0]                we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    addr,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]     wd,
  output logic [NUM_REQ-1:0]                gnt,
  output logic [NUM_REQ-1:0]                rvalid,
  output logic [WIDTH-1:0]                  rdata,
  output logic [ADDR_W-1:0]                 ram_addr,
  output logic                              ram_we,
  output logic                              ram_re,
  output logic [WIDTH-1:0]                  ram_d,
  input  logic [WIDTH-1:0]                  ram_q
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  rf_arb_state_t        state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;

  logic [NUM_REQ-1:0]   rr_gnt;
  logic [IW-1:0]        rr_idx;
  logic [NUM_REQ-1:0]   gnt_raw;
  logic [IW-1:0]        gnt_idx;
  logic                 any_gnt;
  logic                 ptr_upd;

  rf_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  always_comb begin
    gnt_raw = '0;
    gnt_idx = '0;
    unique case (state_q)
      OWN: begin
        if (req[owner_q]) begin
          gnt_raw[owner_q] = 1'b1;
          gnt_idx          = owner_q;
        end
      end
      default: begin
        gnt_raw = rr_gnt;
        gnt_idx = rr_idx;
`ifdef RF_ARB_PRIO0_EN
        if (req[0]) begin
          gnt_raw    = '0;
          gnt_raw[0] = 1'b1;
          gnt_idx    = '0;
        end
`endif
      end
    endcase
  end

  // Gating with rst_n kills grants during reset even if req is held.
  assign gnt      = rst_n ? gnt_raw : '0;
  assign any_gnt  = |gnt;
  assign ram_we   = any_gnt & we[gnt_idx];
  assign ram_re   = any_gnt & ~we[gnt_idx];
  assign ram_addr = any_gnt ? addr[gnt_idx] : '0;
  assign ram_d    = any_gnt ? wd[gnt_idx] : '0;
  assign rvalid   = rvalid_q;
  assign rdata    = ram_q;

  always_comb begin
    rvalid_d = gnt & ~we;
    state_d  = state_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    rr_ptr_d = rr_ptr_q;
    ptr_upd  = 1'b1;
`ifdef RF_ARB_PRIO0_EN
    ptr_upd  = (gnt_idx != '0);
`endif
    if (any_gnt) begin
      if (ptr_upd) rr_ptr_d = gnt_idx;
      if (state_q == ARB) begin
        if (lock[gnt_idx]) begin
          state_d = OWN;
          owner_d = gnt_idx;
          hold_d  = HW'(1);
        end
      end else if (!lock[gnt_idx] || hold_q == HOLD_LAST) begin
        state_d = ARB;
        hold_d  = '0;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end else if (state_q == OWN && !req[owner_q] && !lock[owner_q]) begin
      state_d = ARB;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      owner_q  <= '0;
      rr_ptr_q <= IW'(NUM_REQ - 1);
      hold_q   <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_rf_port_arb.sv
// Directed bench for rf_port_arb with a behavioural single-port RAM.
// Build with RF_ARB_PRIO0_EN to exercise requester-0 priority.
module tb_rf_port_arb;

  localparam int N  = 3;
  localparam int W  = 1408;
  localparam int AW = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      lock = '0;
  logic [N-1:0]      we = '0;
  logic [N-1:0][AW-1:0] addr = '0;
  logic [N-1:0][W-1:0]  wd = '0;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [W-1:0]      rdata;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic              ram_re;
  logic [W-1:0]      ram_d;
  logic [W-1:0]      ram_q = '0;

  logic [W-1:0]      mem [512];
  logic [W-1:0]      pat_a5;
  logic [W-1:0]      pat_33;
  logic [N-1:0]      exp_g;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_port_arb #(
    .NUM_REQ  (N),
    .WIDTH    (W),
    .ADDR_W   (AW),
    .MAX_HOLD (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .we       (we),
    .addr     (addr),
    .wd       (wd),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_d    (ram_d),
    .ram_q    (ram_q)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic [N-1:0] w);
    @(negedge clk);
    req  = r;
    lock = l;
    we   = w;
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if (gnt !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_gnt: got %b want 000", gnt);
    end
    n_cmp++;
    if (rvalid !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_rvalid: got %b want 000", rvalid);
    end
    n_cmp++;
    if ({ram_we, ram_re} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ram_ctl: got %b want 00", {ram_we, ram_re});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read;
    addr[1] = 9'h005;
    step(3'b010, 3'b000, 3'b000);
    n_cmp++;
    if (gnt !== 3'b010) begin
      n_bad++;
      $display("FAIL single_gnt: got %b want 010", gnt);
    end
    n_cmp++;
    if ({ram_re, ram_we, ram_addr} !== {2'b10, 9'h005}) begin
      n_bad++;
      $display("FAIL single_ram: got re=%b we=%b a=%h want re=1 we=0 a=005",
               ram_re, ram_we, ram_addr);
    end
    step(3'b000, 3'b000, 3'b000);
    n_cmp++;
    if (rvalid !== 3'b010) begin
      n_bad++;
      $display("FAIL single_rvalid: got %b want 010", rvalid);
    end
    n_cmp++;
    if (rdata !== pat_a5) begin
      n_bad++;
      $display("FAIL single_rdata: got %h want %h", rdata[31:0], pat_a5[31:0]);
    end
    n_cmp++;
    if ({gnt, ram_addr} !== {3'b000, 9'h000}) begin
      n_bad++;
      $display("FAIL idle_drive: got g=%b a=%h want g=000 a=000", gnt, ram_addr);
    end
  endtask

  task automatic test_contention;
    step(3'b100, 3'b000, 3'b000);
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_bad++;
      $display("FAIL cont_pre: got %b want 100", gnt);
    end
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 3'b000, 3'b000);
      exp_g = 3'b001 << (i % 3);
      n_cmp++;
      if (gnt !== exp_g) begin
        n_bad++;
        $display("FAIL cont_%0d: got %b want %b", i, gnt, exp_g);
      end
    end
    step(3'b000, 3'b000, 3'b000);
    n_cmp++;
    if (rvalid !== 3'b100) begin
      n_bad++;
      $display("FAIL cont_rvalid: got %b want 100", rvalid);
    end
  endtask

  task automatic test_lock_pair;
    addr[0] = 9'h010;
    step(3'b111, 3'b001, 3'b000);
    n_cmp++;
    if (gnt !== 3'b001) begin
      n_bad++;
      $display("FAIL lock_first: got %b want 001", gnt);
    end
    addr[0] = 9'h020;
    step(3'b111, 3'b000, 3'b001);
    n_cmp++;
    if ({gnt, ram_we, ram_addr} !== {3'b001, 1'b1, 9'h020}) begin
      n_bad++;
      $display("FAIL lock_second: got g=%b we=%b a=%h want g=001 we=1 a=020",
               gnt, ram_we, ram_addr);
    end
    n_cmp++;
    if (rvalid !== 3'b001) begin
      n_bad++;
      $display("FAIL lock_rvalid: got %b want 001", rvalid);
    end
    step(3'b110, 3'b000, 3'b000);
    n_cmp++;
    if (gnt !== 3'b010) begin
      n_bad++;
      $display("FAIL lock_after: got %b want 010", gnt);
    end
  endtask

  task automatic test_owner_release;
    step(3'b010, 3'b010, 3'b000);
    n_cmp++;
    if (gnt !== 3'b010) begin
      n_bad++;
      $display("FAIL own_take: got %b want 010", gnt);
    end
    step(3'b100, 3'b010, 3'b000);
    n_cmp++;
    if (gnt !== 3'b000) begin
      n_bad++;
      $display("FAIL own_idle_wait: got %b want 000", gnt);
    end
    step(3'b100, 3'b000, 3'b000);
    n_cmp++;
    if (gnt !== 3'b000) begin
      n_bad++;
      $display("FAIL own_drop: got %b want 000", gnt);
    end
    step(3'b100, 3'b000, 3'b000);
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_bad++;
      $display("FAIL own_released: got %b want 100", gnt);
    end
  endtask

  task automatic test_forced_release;
    step(3'b100, 3'b100, 3'b000);
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_bad++;
      $display("FAIL force_c1: got %b want 100", gnt);
    end
    for (int k = 2; k <= 20; k++) begin
      step(3'b101, 3'b100, 3'b000);
      exp_g = (k == 17) ? 3'b001 : 3'b100;
      n_cmp++;
      if (gnt !== exp_g) begin
        n_bad++;
        $display("FAIL force_c%0d: got %b want %b", k, gnt, exp_g);
      end
    end
    step(3'b000, 3'b000, 3'b000);
    n_cmp++;
    if (gnt !== 3'b000) begin
      n_bad++;
      $display("FAIL force_end: got %b want 000", gnt);
    end
  endtask

  task automatic test_back_to_back;
    addr[0] = 9'h007;
    wd[0]   = pat_33;
    step(3'b001, 3'b000, 3'b001);
    n_cmp++;
    if ({gnt, ram_we, ram_re} !== {3'b001, 2'b10}) begin
      n_bad++;
      $display("FAIL b2b_write: got g=%b we=%b re=%b want g=001 we=1 re=0",
               gnt, ram_we, ram_re);
    end
    step(3'b001, 3'b000, 3'b000);
    n_cmp++;
    if ({gnt, ram_re, rvalid} !== {3'b001, 1'b1, 3'b000}) begin
      n_bad++;
      $display("FAIL b2b_read: got g=%b re=%b rv=%b want g=001 re=1 rv=000",
               gnt, ram_re, rvalid);
    end
    step(3'b000, 3'b000, 3'b000);
    n_cmp++;
    if (rvalid !== 3'b001) begin
      n_bad++;
      $display("FAIL b2b_rvalid: got %b want 001", rvalid);
    end
    n_cmp++;
    if (rdata !== pat_33) begin
      n_bad++;
      $display("FAIL b2b_rdata: got %h want %h", rdata[31:0], pat_33[31:0]);
    end
  endtask

  task automatic test_reset_in_own;
    addr[1] = 9'h005;
    step(3'b010, 3'b010, 3'b000);
    n_cmp++;
    if (gnt !== 3'b010) begin
      n_bad++;
      $display("FAIL rst_own_take: got %b want 010", gnt);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, rvalid} !== 6'b000000) begin
      n_bad++;
      $display("FAIL rst_own_drop: got g=%b rv=%b want g=000 rv=000", gnt, rvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 3'b100;
    lock  = 3'b000;
    #1;
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_bad++;
      $display("FAIL rst_own_after: got %b want 100", gnt);
    end
  endtask

  task automatic test_prio0;
`ifdef RF_ARB_PRIO0_EN
    for (int i = 0; i < 3; i++) begin
      step(3'b111, 3'b000, 3'b000);
      n_cmp++;
      if (gnt !== 3'b001) begin
        n_bad++;
        $display("FAIL prio0_%0d: got %b want 001", i, gnt);
      end
    end
`endif
    step(3'b000, 3'b000, 3'b000);
  endtask

  initial begin
    pat_a5 = {176{8'hA5}};
    pat_33 = '0;
    pat_33[7:0] = 8'h33;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[5] = pat_a5;
    test_reset();
    test_single_read();
    test_contention();
    test_lock_pair();
    test_owner_release();
    test_forced_release();
    test_back_to_back();
    test_reset_in_own();
    test_prio0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
